audio_info_frame_parser: RTL

AUDIO_INFO_FRAME_PARSER -- requirements
Module: audio_info_frame_parser

---
 rtl/audio_info_frame_parser.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/audio_info_frame_parser.sv
// audio_info_frame_parser
// Parses a 31-byte audio InfoFrame byte stream (HB0..HB2, PB0..PB27),
// validates the header and checksum and publishes the decoded audio fields.
//
// Ports:
//   clk_pixel           sole clock, rising edge
//   reset_n             asynchronous active-low reset
//   in_valid            in_data carries a packet byte this cycle
//   in_start            with in_valid: byte is HB0 of a new packet
//   in_data[7:0]        packet byte stream
//   coding_type[3:0]    PB1[7:4]
//   channel_count[2:0]  PB1[2:0]
//   sampling_frequency  PB2[4:2]
//   sample_size[1:0]    PB2[1:0]
//   channel_allocation  PB4
//   down_mix_inhibited  PB5[7]
//   level_shift_value   PB5[6:3]
//   lfe_playback_level  PB5[1:0]
//   fields_loaded       high once any frame has been accepted
//   frame_valid         one-cycle pulse: frame accepted, fields updated
//   checksum_error      one-cycle pulse: header good, checksum bad
//   header_error        one-cycle pulse: header mismatch
module audio_info_frame_parser #(
  parameter logic [7:0] EXPECTED_TYPE    = 8'h84,
  parameter logic [7:0] EXPECTED_VERSION = 8'h01,
  parameter logic [4:0] EXPECTED_LENGTH  = 5'd10
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic       in_start,
  input  logic [7:0] in_data,
  output logic [3:0] coding_type,
  output logic [2:0] channel_count,
  output logic [2:0] sampling_frequency,
  output logic [1:0] sample_size,
  output logic [7:0] channel_allocation,
  output logic       down_mix_inhibited,
  output logic [3:0] level_shift_value,
  output logic [1:0] lfe_playback_level,
  output logic       fields_loaded,
  output logic       frame_valid,
  output logic       checksum_error,
  output logic       header_error
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_BODY   = 2'd2
  } state_t;

  localparam logic [4:0] LAST_IDX     = 5'd30;
  // Highest byte index that contributes to the checksum (HB0..PB(LENGTH)).
  localparam logic [5:0] LAST_SUM_IDX = {1'b0, EXPECTED_LENGTH} + 6'd3;

  // Modulo-256 checksum accumulation.
  function automatic logic [7:0] checksum_add(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

  // HB2: length field must match and the reserved upper bits must be zero.
  function automatic logic hb2_ok(input logic [7:0] data);
    return (data[4:0] == EXPECTED_LENGTH) && (data[7:5] == 3'b000);
  endfunction

  state_t     state_r, state_next_s;
  logic [4:0] idx_r, idx_next_s;      // index of the most recently consumed byte
  logic [7:0] sum_r, sum_next_s;
  logic       hdr_ok_r, hdr_ok_next_s;
  logic [7:0] pb1_r, pb2_r, pb4_r, pb5_r;

  logic       consume_s;               // non-start byte of an open packet
  logic [4:0] byte_idx_s;              // index of the byte being consumed
  logic       last_byte_s;
  logic       frame_valid_next_s;
  logic       checksum_error_next_s;
  logic       header_error_next_s;

  assign consume_s   = in_valid && !in_start && (state_r != ST_IDLE);
  assign byte_idx_s  = idx_r + 5'd1;
  assign last_byte_s = consume_s && (state_r == ST_BODY) && (byte_idx_s == LAST_IDX);

  // State register with packet index, running checksum and header flag.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      idx_r    <= 5'd0;
      sum_r    <= 8'h00;
      hdr_ok_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      idx_r    <= idx_next_s;
      sum_r    <= sum_next_s;
      hdr_ok_r <= hdr_ok_next_s;
    end
  end

  // Next-state logic: in_start restarts from any state, other bytes advance.
  always_comb begin
    state_next_s  = state_r;
    idx_next_s    = idx_r;
    sum_next_s    = sum_r;
    hdr_ok_next_s = hdr_ok_r;
    if (in_valid && in_start) begin
      state_next_s  = ST_HEADER;
      idx_next_s    = 5'd0;
      sum_next_s    = in_data;
      hdr_ok_next_s = (in_data == EXPECTED_TYPE);
    end else if (consume_s) begin
      idx_next_s = byte_idx_s;
      if ({1'b0, byte_idx_s} <= LAST_SUM_IDX) begin
        sum_next_s = checksum_add(sum_r, in_data);
      end else begin
        sum_next_s = sum_r;
      end
      case (state_r)
        ST_HEADER: begin
          if (byte_idx_s == 5'd1) begin
            hdr_ok_next_s = hdr_ok_r && (in_data == EXPECTED_VERSION);
          end else begin
            hdr_ok_next_s = hdr_ok_r && hb2_ok(in_data);
            state_next_s  = ST_BODY;
          end
        end
        ST_BODY: begin
          if (byte_idx_s == LAST_IDX) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_BODY;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Result decode on the final byte; header mismatch outranks checksum.
  always_comb begin
    frame_valid_next_s    = 1'b0;
    checksum_error_next_s = 1'b0;
    header_error_next_s   = 1'b0;
    if (last_byte_s) begin
      if (!hdr_ok_r) begin
        header_error_next_s = 1'b1;
      end else if (sum_next_s != 8'h00) begin
        checksum_error_next_s = 1'b1;
      end else begin
        frame_valid_next_s = 1'b1;
      end
    end else begin
      frame_valid_next_s = 1'b0;
    end
  end

  // Shadow capture of PB1/PB2/PB4/PB5 while the body streams in.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      pb1_r <= 8'h00;
      pb2_r <= 8'h00;
      pb4_r <= 8'h00;
      pb5_r <= 8'h00;
    end else if (consume_s && (state_r == ST_BODY)) begin
      case (byte_idx_s)
        5'd4:    pb1_r <= in_data;
        5'd5:    pb2_r <= in_data;
        5'd7:    pb4_r <= in_data;
        5'd8:    pb5_r <= in_data;
        default: pb1_r <= pb1_r;
      endcase
    end
  end

  // Registered result pulses.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      frame_valid    <= 1'b0;
      checksum_error <= 1'b0;
      header_error   <= 1'b0;
    end else begin
      frame_valid    <= frame_valid_next_s;
      checksum_error <= checksum_error_next_s;
      header_error   <= header_error_next_s;
    end
  end

  // Decoded fields move from the shadows only when a frame is accepted.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      coding_type        <= 4'd0;
      channel_count      <= 3'd0;
      sampling_frequency <= 3'd0;
      sample_size        <= 2'd0;
      channel_allocation <= 8'h00;
      down_mix_inhibited <= 1'b0;
      level_shift_value  <= 4'd0;
      lfe_playback_level <= 2'd0;
      fields_loaded      <= 1'b0;
    end else if (frame_valid_next_s) begin
      coding_type        <= pb1_r[7:4];
      channel_count      <= pb1_r[2:0];
      sampling_frequency <= pb2_r[4:2];
      sample_size        <= pb2_r[1:0];
      channel_allocation <= pb4_r;
      down_mix_inhibited <= pb5_r[7];
      level_shift_value  <= pb5_r[6:3];
      lfe_playback_level <= pb5_r[1:0];
      fields_loaded      <= 1'b1;
    end
  end

endmodule
